debug_step_ctrl: RTL and testbench
==================================

Name: debug_step_ctrl

Overview:
- Drives the debug_en / debug_step inputs of the 5-stage pipeline controller.
- Turns raw board buttons and switches into clean run/halt/single-step control.
- Adds a PC breakpoint and a run-N-cycles mode.
- Sits at the board top level, between the I/O pins and the CPU controller.

Parameters:
DEBOUNCE_CYCLES, 1000000, number of stable clk cycles before a synchronized button level is accepted
RUNN_W, 16, width of the run-N cycle count

Ports:
clk  input  1  main clock
rst  input  1  reset rst, synchronous, active-high; clock clk
sw_debug  input  1  raw switch; 1 = debug mode, 0 = free run
btn_step  input  1  raw single-step button, async, bouncy
btn_run  input  1  raw run/halt toggle button, async, bouncy
run_n  input  RUNN_W  cycle count for run-N mode
run_n_start  input  1  synchronous one-cycle pulse; start run-N mode
break_en  input  1  breakpoint enable (synchronous)
break_pc  input  32  breakpoint address
pc_if  input  32  PC of the instruction in the IF stage
if_valid  input  1  IF stage valid flag
debug_en  output  1  to controller; 1 = pipeline suspended except on step edge
debug_step  output  1  to controller; a rising edge advances the pipeline one cycle
state  output  3  FSM state: 0 RUN, 1 HALT, 2 STEP, 3 RUN_N
adv_count  output  32  number of cycles in which the pipeline advanced

Behaviour:
- Input conditioning:
  - sw_debug, btn_step and btn_run each pass through a 2-FF synchronizer.
  - btn_step and btn_run are then debounced: a per-button counter resets on any change of the synchronized level. The debounced level updates only after DEBOUNCE_CYCLES consecutive equal samples.
  - A rising edge of a debounced button gives a one-cycle request: step_req or run_req.
  - sw_debug is synchronized only, not debounced.
- All outputs are registered.
- Reset values: state=HALT, debug_en=1, debug_step=0, adv_count=0. Synchronizer and debounce registers clear to 0, and no requests are pending.
- FSM. Per-cycle priority: rst > sw_debug low > breakpoint > run_n_start > run_req > step_req.
  - Any state, sync sw_debug=0: go to RUN.
  - RUN: debug_en=0. On breakpoint hit, go to HALT. On run_req (with sw_debug=1), go to HALT. step_req is ignored.
  - HALT: debug_en=1, debug_step=0.
    - run_req: go to RUN.
    - run_n_start: if run_n≠0, latch run_n into the down-counter and go to RUN_N; if run_n=0, stay in HALT.
    - step_req: go to STEP.
  - STEP: debug_en=1, debug_step=1 for exactly one cycle, then unconditionally back to HALT.
    - The controller registers debug_step, so exactly one pipeline advance occurs per step.
    - A button held high gives one step only.
  - RUN_N: debug_en=0.
    - The counter decrements every cycle. When it reaches 0, go to HALT, so debug_en is low for exactly run_n cycles.
    - A breakpoint hit goes to HALT early. run_req aborts to HALT.
    - step_req and run_n_start are ignored.
  - Requests not accepted in the current state are dropped, not queued.
- Breakpoint:
  - A hit is break_en && if_valid && pc_if==break_pc, evaluated only in RUN and RUN_N with sw_debug=1.
  - debug_en rises in the cycle after the hit, so the pipeline advances once more and the matching instruction is held in ID.
  - On leaving HALT via run_req, the hit is masked for one cycle so execution can resume past the breakpoint.
- adv_count:
  - Increments (32-bit wrap) in every cycle where the registered debug_en=0, or where debug_step=1 in STEP.
  - Cleared only by rst.
- sw_debug falling while in STEP: the step pulse completes; the next state is RUN, not HALT.

Test Plan:
- rst, sw_debug=1, DEBOUNCE_CYCLES=4 -> state=HALT, debug_en=1, debug_step=0, adv_count=0; no change for 100 cycles.
- Bench uses DEBOUNCE_CYCLES=4. btn_step bounces 0/1 every 2 cycles for 20 cycles, then holds 1 for 50 cycles -> exactly one STEP cycle and one debug_step=1 pulse; adv_count=1; held button gives no further pulses.
- HALT, run_n=5, run_n_start pulse -> debug_en=0 for exactly 5 cycles, then HALT; adv_count +5. Repeat with run_n=0 -> stays HALT, adv_count unchanged.
- RUN with break_en=1, break_pc=0x0000_0010, pc_if steps through 0x0,0x4,...,0x10 with if_valid=1 -> debug_en=1 in the cycle after pc_if=0x10. After a run_req, the pipeline resumes without an immediate re-halt.
- RUN_N with run_n=100, breakpoint hit at cycle 7 -> HALT after 8 advance cycles, counter abandoned.
- sw_debug 1→0 while in HALT -> RUN (debug_en=0) three cycles later, after the 2-FF sync plus register. sw_debug 0→1 -> stays RUN until run_req; rst mid-RUN_N -> HALT, adv_count=0.

Source files
------------

// File: rtl/debug_step_ctrl.sv
// Board-level run/halt/single-step controller feeding debug_en/debug_step of the CPU controller.
// Conditions raw switch/buttons and adds a PC breakpoint plus a run-N-cycles mode.
module debug_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RUNN_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_debug,
    input  logic              btn_step,
    input  logic              btn_run,
    input  logic [RUNN_W-1:0] run_n,
    input  logic              run_n_start,
    input  logic              break_en,
    input  logic [31:0]       break_pc,
    input  logic [31:0]       pc_if,
    input  logic              if_valid,
    output logic              debug_en,
    output logic              debug_step,
    output logic [2:0]        state,
    output logic [31:0]       adv_count
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StRun  = 3'd0,
        StHalt = 3'd1,
        StStep = 3'd2,
        StRunN = 3'd3
    } state_e;

    // Input conditioning; bit 0 = step button, bit 1 = run button
    logic [1:0]      sw_sync_q;
    logic [1:0]      fill_q;
    logic [1:0]      btn_s1_q;
    logic [1:0]      btn_s2_q;
    logic [1:0]      btn_db_q;
    logic [1:0]      btn_db_d;
    logic [1:0]      btn_db_dly_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    logic step_req;
    logic run_req;
    logic sw_on;

    // FSM and outputs
    state_e            state_q;
    state_e            state_d;
    logic [RUNN_W-1:0] run_cnt_q;
    logic [RUNN_W-1:0] run_cnt_d;
    logic              mask_q;
    logic              mask_d;
    logic              bp_hit;
    logic              debug_en_q;
    logic              debug_step_q;
    logic [31:0]       adv_q;

    // Counter runs while the synchronized level differs from the accepted one; any
    // return to the accepted level restarts it.
    always_comb begin
        btn_db_d = btn_db_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (btn_s2_q[i] != btn_db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    btn_db_d[i] = btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync_q    <= '0;
            fill_q       <= '0;
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            btn_db_q     <= '0;
            btn_db_dly_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sw_sync_q    <= {sw_sync_q[0], sw_debug};
            fill_q       <= {fill_q[0], 1'b1};
            btn_s1_q     <= {btn_run, btn_step};
            btn_s2_q     <= btn_s1_q;
            btn_db_q     <= btn_db_d;
            btn_db_dly_q <= btn_db_q;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign step_req = btn_db_q[0] & ~btn_db_dly_q[0];
    assign run_req  = btn_db_q[1] & ~btn_db_dly_q[1];

    // The switch synchronizer clears to 0 on reset; until it holds a real sample the
    // switch is treated as on, so reset lands and stays in HALT.
    assign sw_on = sw_sync_q[1] | ~fill_q[1];

    assign bp_hit = break_en & if_valid & (pc_if == break_pc) & ~mask_q;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        mask_d    = 1'b0;
        if (!sw_on) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bp_hit || run_req) begin
                        state_d = StHalt;
                    end
                end
                StHalt: begin
                    if (run_n_start) begin
                        if (run_n != '0) begin
                            run_cnt_d = run_n;
                            state_d   = StRunN;
                        end
                    end else if (run_req) begin
                        // Let execution resume past an instruction sitting on the breakpoint
                        state_d = StRun;
                        mask_d  = 1'b1;
                    end else if (step_req) begin
                        state_d = StStep;
                    end
                end
                StStep: begin
                    state_d = StHalt;
                end
                StRunN: begin
                    run_cnt_d = run_cnt_q - 1'b1;
                    if (bp_hit || run_req || (run_cnt_q == RUNN_W'(1))) begin
                        state_d = StHalt;
                    end
                end
                default: begin
                    state_d = StHalt;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StHalt;
            run_cnt_q    <= '0;
            mask_q       <= 1'b0;
            debug_en_q   <= 1'b1;
            debug_step_q <= 1'b0;
            adv_q        <= '0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            mask_q       <= mask_d;
            debug_en_q   <= (state_d == StHalt) || (state_d == StStep);
            debug_step_q <= (state_d == StStep);
            adv_q        <= adv_q + {31'd0, (~debug_en_q | debug_step_q)};
        end
    end

    assign debug_en   = debug_en_q;
    assign debug_step = debug_step_q;
    assign state      = state_q;
    assign adv_count  = adv_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl: randomized button, run-N and breakpoint scenarios
// with expectations derived from the step/run-N/breakpoint rules.
module tb_debug_step_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned RW = 16;
    localparam logic [2:0] S_RUN  = 3'd0;
    localparam logic [2:0] S_HALT = 3'd1;
    localparam logic [2:0] S_STEP = 3'd2;
    localparam logic [2:0] S_RUNN = 3'd3;

    logic          clk;
    logic          rst;
    logic          sw_debug;
    logic          btn_step;
    logic          btn_run;
    logic [RW-1:0] run_n;
    logic          run_n_start;
    logic          break_en;
    logic [31:0]   break_pc;
    logic [31:0]   pc_if;
    logic          if_valid;
    logic          debug_en;
    logic          debug_step;
    logic [2:0]    state;
    logic [31:0]   adv_count;

    int   checks;
    int   failures;
    int   step_seen;
    int   pulse_seen;
    logic step_prev;
    logic stub_en;
    logic en_prev;

    debug_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RUNN_W         (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_debug   (sw_debug),
        .btn_step   (btn_step),
        .btn_run    (btn_run),
        .run_n      (run_n),
        .run_n_start(run_n_start),
        .break_en   (break_en),
        .break_pc   (break_pc),
        .pc_if      (pc_if),
        .if_valid   (if_valid),
        .debug_en   (debug_en),
        .debug_step (debug_step),
        .state      (state),
        .adv_count  (adv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; a tiny pipeline stub moves pc_if on after every cycle the pipeline advanced.
    task automatic tick();
        en_prev = debug_en;
        @(posedge clk);
        #1;
        if (stub_en && !en_prev) pc_if = pc_if + 32'd4;
        if (state == S_STEP) step_seen++;
        if (debug_step && !step_prev) pulse_seen++;
        step_prev = debug_step;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        sw_debug    = 1'b1;
        btn_step    = 1'b0;
        btn_run     = 1'b0;
        run_n       = '0;
        run_n_start = 1'b0;
        break_en    = 1'b0;
        break_pc    = 32'hFFFF_FFF0;
        pc_if       = 32'd0;
        if_valid    = 1'b1;
        stub_en     = 1'b0;
        repeat (3) tick();
        rst        = 1'b0;
        step_seen  = 0;
        pulse_seen = 0;
    endtask

    task automatic press(input bit is_run);
        if (is_run) btn_run = 1'b1;
        else btn_step = 1'b1;
        repeat (DB + 6) tick();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        repeat (DB + 6) tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound);
        int n;
        n = 0;
        while (state !== s && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state !== S_HALT) begin
            failures++;
            $display("FAIL reset_state got=%0d want=%0d", state, S_HALT);
        end
        checks++;
        if (debug_en !== 1'b1 || debug_step !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got en=%b step=%b want en=1 step=0", debug_en, debug_step);
        end
        checks++;
        if (adv_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_adv got=%0d want=0", adv_count);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({state, debug_en, debug_step, adv_count} !== {S_HALT, 1'b1, 1'b0, 32'd0}) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got state=%0d en=%b step=%b adv=%0d want 1/1/0/0",
                         i, state, debug_en, debug_step, adv_count);
            end
        end
    endtask

    task automatic test_step_debounce();
        int k;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            btn_step = ((i / 2) % 2) == 1;
            tick();
        end
        btn_step = 1'b1;
        repeat (50) tick();
        btn_step = 1'b0;
        repeat (DB + 6) tick();
        checks++;
        if (step_seen !== 1 || pulse_seen !== 1) begin
            failures++;
            $display("FAIL step_bounce got step_cycles=%0d pulses=%0d want 1/1", step_seen, pulse_seen);
        end
        checks++;
        if (adv_count !== 32'd1 || state !== S_HALT) begin
            failures++;
            $display("FAIL step_bounce_adv got adv=%0d state=%0d want 1/%0d", adv_count, state, S_HALT);
        end
        k = $urandom_range(2, 4);
        step_seen  = 0;
        pulse_seen = 0;
        repeat (k) press(1'b0);
        // Glitches shorter than the debounce window must never register
        for (int j = 0; j < 12; j++) begin
            btn_step = 1'b1;
            repeat ($urandom_range(1, DB - 1)) tick();
            btn_step = 1'b0;
            repeat ($urandom_range(1, DB + 2)) tick();
        end
        repeat (DB + 6) tick();
        checks++;
        if (step_seen !== k || pulse_seen !== k) begin
            failures++;
            $display("FAIL step_random got step_cycles=%0d pulses=%0d want %0d", step_seen, pulse_seen, k);
        end
        checks++;
        if (adv_count !== 32'(k + 1)) begin
            failures++;
            $display("FAIL step_random_adv got=%0d want=%0d", adv_count, k + 1);
        end
    endtask

    task automatic test_run_n();
        int exp_adv;
        int r;
        int low;
        int guard;
        do_reset();
        exp_adv = 0;
        for (int t = 0; t < 4; t++) begin
            r = (t == 0) ? 5 : $urandom_range(1, 30);
            run_n = RW'(r);
            run_n_start = 1'b1;
            tick();
            run_n_start = 1'b0;
            run_n = RW'($urandom);
            low = 0;
            guard = 0;
            while (state !== S_HALT && guard < r + 20) begin
                if (!debug_en) low++;
                tick();
                guard++;
            end
            exp_adv += r;
            checks++;
            if (low !== r || state !== S_HALT) begin
                failures++;
                $display("FAIL run_n_len run_n=%0d got low=%0d state=%0d want low=%0d state=%0d",
                         r, low, state, r, S_HALT);
            end
            checks++;
            if (adv_count !== 32'(exp_adv)) begin
                failures++;
                $display("FAIL run_n_adv got=%0d want=%0d", adv_count, exp_adv);
            end
        end
        run_n = '0;
        run_n_start = 1'b1;
        tick();
        run_n_start = 1'b0;
        repeat (10) tick();
        checks++;
        if (state !== S_HALT || debug_en !== 1'b1 || adv_count !== 32'(exp_adv)) begin
            failures++;
            $display("FAIL run_n_zero got state=%0d en=%b adv=%0d want %0d/1/%0d",
                     state, debug_en, adv_count, S_HALT, exp_adv);
        end
    endtask

    task automatic test_breakpoint();
        int k;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            k = (it == 0) ? 4 : $urandom_range(2, 12);
            break_pc = 32'(4 * k);
            break_en = 1'b1;
            stub_en  = 1'b1;
            press(1'b1);
            wait_state(S_HALT, 100);
            checks++;
            if (state !== S_HALT || debug_en !== 1'b1) begin
                failures++;
                $display("FAIL bp_halt pc=%0h got state=%0d en=%b want %0d/1",
                         break_pc, state, debug_en, S_HALT);
            end
            checks++;
            if (adv_count !== 32'(k + 1) || pc_if !== break_pc + 32'd4) begin
                failures++;
                $display("FAIL bp_adv pc=%0h got adv=%0d pc_if=%0h want adv=%0d pc_if=%0h",
                         break_pc, adv_count, pc_if, k + 1, break_pc + 32'd4);
            end
            // Resume with the breakpoint instruction back in IF
            pc_if = break_pc;
            press(1'b1);
            checks++;
            if (state !== S_RUN || debug_en !== 1'b0) begin
                failures++;
                $display("FAIL bp_resume got state=%0d en=%b want %0d/0", state, debug_en, S_RUN);
            end
            press(1'b1);
            checks++;
            if (state !== S_HALT) begin
                failures++;
                $display("FAIL bp_rehalt got state=%0d want %0d", state, S_HALT);
            end
        end
    endtask

    task automatic test_runn_break();
        int k;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            k = (it == 0) ? 7 : $urandom_range(2, 10);
            break_pc = 32'(4 * k);
            break_en = 1'b1;
            stub_en  = 1'b1;
            run_n = RW'(100);
            run_n_start = 1'b1;
            tick();
            run_n_start = 1'b0;
            wait_state(S_HALT, 200);
            checks++;
            if (state !== S_HALT || adv_count !== 32'(k + 1)) begin
                failures++;
                $display("FAIL runn_bp hit=%0d got state=%0d adv=%0d want %0d/%0d",
                         k, state, adv_count, S_HALT, k + 1);
            end
            repeat (110) tick();
            checks++;
            if (state !== S_HALT || adv_count !== 32'(k + 1)) begin
                failures++;
                $display("FAIL runn_bp_abandon got state=%0d adv=%0d want %0d/%0d",
                         state, adv_count, S_HALT, k + 1);
            end
        end
    endtask

    task automatic test_sw_debug();
        do_reset();
        sw_debug = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== S_HALT || debug_en !== 1'b1) begin
            failures++;
            $display("FAIL sw_early got state=%0d en=%b want %0d/1", state, debug_en, S_HALT);
        end
        tick();
        checks++;
        if (state !== S_RUN || debug_en !== 1'b0) begin
            failures++;
            $display("FAIL sw_run got state=%0d en=%b want %0d/0", state, debug_en, S_RUN);
        end
        sw_debug = 1'b1;
        repeat (10) tick();
        press(1'b0);
        checks++;
        if (state !== S_RUN) begin
            failures++;
            $display("FAIL sw_stay_run got state=%0d want %0d", state, S_RUN);
        end
        press(1'b1);
        checks++;
        if (state !== S_HALT || debug_en !== 1'b1) begin
            failures++;
            $display("FAIL sw_run_req got state=%0d en=%b want %0d/1", state, debug_en, S_HALT);
        end
        run_n = RW'(50);
        run_n_start = 1'b1;
        tick();
        run_n_start = 1'b0;
        repeat (5) tick();
        checks++;
        if (state !== S_RUNN) begin
            failures++;
            $display("FAIL rst_pre got state=%0d want %0d", state, S_RUNN);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({state, debug_en, debug_step, adv_count} !== {S_HALT, 1'b1, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL rst_mid_runn got state=%0d en=%b step=%b adv=%0d want 1/1/0/0",
                     state, debug_en, debug_step, adv_count);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        step_seen = 0;
        pulse_seen = 0;
        step_prev = 1'b0;
        en_prev   = 1'b1;
        stub_en   = 1'b0;
        test_reset();
        test_step_debounce();
        test_run_n();
        test_breakpoint();
        test_runn_break();
        test_sw_debug();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
